target_round_sequencer: RTL and testbench

Upstream stage of the game datapath. It turns the free-running LFSR box value into a held target for a timed round and debounces the raw Arduino box address. It emits one-cycle hit, miss and timeout events plus the active target, which the score datapath consumes. This replaces the datapath's raw per-cycle LFSR-versus-sensor comparison with one event per physical strike.

---
 rtl/target_round_sequencer_pkg.sv | 27 ++
 rtl/target_round_sequencer_if.sv | 26 ++
 rtl/target_round_sequencer_strike_debouncer.sv | 70 +++++++
 rtl/target_round_sequencer.sv | 174 +++++++++++++++++
 tb/tb_target_round_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/target_round_sequencer_pkg.sv
// Shared types and constants for the target round sequencer and its debouncer.
package target_round_sequencer_pkg;

    localparam int unsigned BOX_W  = 3;
    localparam int unsigned DIFF_W = 2;
    localparam int unsigned WIN_W  = 16;
    localparam int unsigned RC_W   = 8;

    localparam logic [BOX_W-1:0] NO_BOX  = BOX_W'(0);
    localparam logic [BOX_W-1:0] MAX_BOX = BOX_W'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_COOLDOWN
    } seq_state_e;

    // Never repeat the previous target and never pick the empty box.
    function automatic logic [BOX_W-1:0] next_target(input logic [BOX_W-1:0] lfsr,
                                                     input logic [BOX_W-1:0] prev);
        logic [BOX_W-1:0] succ;
        succ = (prev == MAX_BOX) ? BOX_W'(1) : prev + BOX_W'(1);
        return ((lfsr == NO_BOX) || (lfsr == prev)) ? succ : lfsr;
    endfunction

endpackage

// File: rtl/target_round_sequencer_if.sv
// Game-control and event bus between the game datapath and the round sequencer.
interface target_round_sequencer_if;
    import target_round_sequencer_pkg::*;

    logic                start_game;
    logic [DIFF_W-1:0]   difficulty_level;
    logic [BOX_W-1:0]    lfsr_value;
    logic [BOX_W-1:0]    box_address;
    logic [BOX_W-1:0]    target_box;
    logic                target_valid;
    logic                hit_pulse;
    logic                miss_pulse;
    logic                timeout_pulse;
    logic [RC_W-1:0]     round_count;

    modport master (
        output start_game, difficulty_level, lfsr_value, box_address,
        input  target_box, target_valid, hit_pulse, miss_pulse, timeout_pulse, round_count
    );

    modport slave (
        input  start_game, difficulty_level, lfsr_value, box_address,
        output target_box, target_valid, hit_pulse, miss_pulse, timeout_pulse, round_count
    );

endinterface

// File: rtl/target_round_sequencer_strike_debouncer.sv
// Turns the raw sensor box address into one strike pulse per physical hit;
// a new strike needs the sensor to settle back to NO_BOX first.
module target_round_sequencer_strike_debouncer
    import target_round_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [BOX_W-1:0] box_address,
    output logic             strike,
    output logic [BOX_W-1:0] strike_box
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [BOX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rearm_q, rearm_d;
    logic             strike_q, strike_d;
    logic [BOX_W-1:0] sbox_q, sbox_d;
    logic             same_c;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            last_q   <= NO_BOX;
            cnt_q    <= '0;
            rearm_q  <= 1'b1;
            strike_q <= 1'b0;
            sbox_q   <= NO_BOX;
        end else begin
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rearm_q  <= rearm_d;
            strike_q <= strike_d;
            sbox_q   <= sbox_d;
        end
    end

    // Count consecutive identical samples; act only on the cycle the count matures.
    always_comb begin
        last_d   = box_address;
        cnt_d    = cnt_q;
        rearm_d  = rearm_q;
        strike_d = 1'b0;
        sbox_d   = sbox_q;
        same_c   = (box_address == last_q);

        if (!same_c) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if ((cnt_d == CNT_MAX) && (!same_c || (cnt_q != CNT_MAX))) begin
            if (box_address == NO_BOX) begin
                rearm_d = 1'b1;
            end else if (rearm_q) begin
                strike_d = 1'b1;
                sbox_d   = box_address;
                rearm_d  = 1'b0;
            end
        end
    end

    assign strike     = strike_q;
    assign strike_box = sbox_q;

endmodule

// File: rtl/target_round_sequencer.sv
// Round sequencer: holds an LFSR-derived target for a timed window and reports
// one hit, miss or timeout event per debounced strike or expired round.
module target_round_sequencer
    import target_round_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MS_CYCLES       = 50000,
    parameter int unsigned WINDOW_L1_MS    = 2000,
    parameter int unsigned WINDOW_L2_MS    = 1500,
    parameter int unsigned WINDOW_L3_MS    = 1000,
    parameter int unsigned COOLDOWN_MS     = 250
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    target_round_sequencer_if.slave    bus
);

    localparam int unsigned MS_W = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [BOX_W-1:0] target_q, target_d;
    logic [BOX_W-1:0] prev_q, prev_d;
    logic             valid_q, valid_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic             timeout_q, timeout_d;
    logic [RC_W-1:0]  round_q, round_d;
    logic [WIN_W-1:0] window_q, window_d;
    logic [WIN_W-1:0] cool_q, cool_d;
    logic [MS_W-1:0]  ms_q, ms_d;

    logic             strike;
    logic [BOX_W-1:0] strike_box;
    logic             ms_tick_c;
    logic             expire_c;
    logic [WIN_W-1:0] win_load_c;
    logic [BOX_W-1:0] sel_target_c;

    target_round_sequencer_strike_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_strike_debouncer (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .box_address (bus.box_address),
        .strike      (strike),
        .strike_box  (strike_box)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            target_q  <= NO_BOX;
            prev_q    <= NO_BOX;
            valid_q   <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            timeout_q <= 1'b0;
            round_q   <= '0;
            window_q  <= '0;
            cool_q    <= '0;
            ms_q      <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            prev_q    <= prev_d;
            valid_q   <= valid_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            timeout_q <= timeout_d;
            round_q   <= round_d;
            window_q  <= window_d;
            cool_q    <= cool_d;
            ms_q      <= ms_d;
        end
    end

    // Difficulty 0 plays like difficulty 1.
    always_comb begin
        case (bus.difficulty_level)
            DIFF_W'(2): win_load_c = WIN_W'(WINDOW_L2_MS);
            DIFF_W'(3): win_load_c = WIN_W'(WINDOW_L3_MS);
            default:    win_load_c = WIN_W'(WINDOW_L1_MS);
        endcase
    end

    assign sel_target_c = next_target(bus.lfsr_value, prev_q);
    assign ms_tick_c    = (ms_q == MS_LAST);
    // A zero window means an expiry deferred by a miss on the expiry cycle.
    assign expire_c     = (window_q == '0) || (ms_tick_c && (window_q == WIN_W'(1)));

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        prev_d    = prev_q;
        valid_d   = valid_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        timeout_d = 1'b0;
        round_d   = round_q;
        window_d  = window_q;
        cool_d    = cool_q;
        ms_d      = ms_q;

        if (!bus.start_game) begin
            state_d  = S_IDLE;
            target_d = NO_BOX;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_LOAD;
                    round_d = '0;
                end
                S_LOAD: begin
                    state_d  = S_ARMED;
                    target_d = sel_target_c;
                    prev_d   = sel_target_c;
                    valid_d  = 1'b1;
                    window_d = win_load_c;
                    ms_d     = '0;
                    if (round_q != '1) begin
                        round_d = round_q + RC_W'(1);
                    end
                end
                S_ARMED: begin
                    ms_d = ms_tick_c ? '0 : ms_q + MS_W'(1);
                    if (ms_tick_c && (window_q != '0)) begin
                        window_d = window_q - WIN_W'(1);
                    end
                    // A strike outranks an expiry landing in the same cycle.
                    if (strike && (strike_box == target_q)) begin
                        hit_d    = 1'b1;
                        state_d  = S_COOLDOWN;
                        target_d = NO_BOX;
                        valid_d  = 1'b0;
                        cool_d   = WIN_W'(COOLDOWN_MS);
                        ms_d     = '0;
                    end else if (strike) begin
                        miss_d = 1'b1;
                    end else if (expire_c) begin
                        timeout_d = 1'b1;
                        state_d   = S_COOLDOWN;
                        target_d  = NO_BOX;
                        valid_d   = 1'b0;
                        cool_d    = WIN_W'(COOLDOWN_MS);
                        ms_d      = '0;
                    end
                end
                S_COOLDOWN: begin
                    ms_d = ms_tick_c ? '0 : ms_q + MS_W'(1);
                    if (ms_tick_c) begin
                        if (cool_q <= WIN_W'(1)) begin
                            state_d = S_LOAD;
                        end else begin
                            cool_d = cool_q - WIN_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.target_box    = target_q;
    assign bus.target_valid  = valid_q;
    assign bus.hit_pulse     = hit_q;
    assign bus.miss_pulse    = miss_q;
    assign bus.timeout_pulse = timeout_q;
    assign bus.round_count   = round_q;

endmodule

// File: tb/tb_target_round_sequencer.sv
// Directed scoreboard bench: stimulus queues expected events with their edge number,
// a negedge monitor pops and compares each event the sequencer emits.
module tb_target_round_sequencer;

    localparam logic [2:0] K_HIT = 3'b001;
    localparam logic [2:0] K_MIS = 3'b010;
    localparam logic [2:0] K_TMO = 3'b100;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    target_round_sequencer_if bus();

    target_round_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .MS_CYCLES       (10),
        .WINDOW_L1_MS    (5),
        .COOLDOWN_MS     (2)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [2:0] kind;
        exp_t       e;
        kind = {bus.timeout_pulse, bus.miss_pulse, bus.hit_pulse};
        if (kind != 3'b000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event edge=%0d kind=%b required none", cyc, kind);
            end else begin
                e = exp_q.pop_front();
                if ((e.kind != kind) || (e.cyc != cyc)) begin
                    errors++;
                    $display("FAIL event got kind=%b edge=%0d required kind=%b edge=%0d",
                             kind, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s edge=%0d got %0d required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_ev(input logic [2:0] kind, input int at);
        exp_q.push_back('{kind: kind, cyc: at});
    endtask

    task automatic chk_round(input string name, input int tgt, input int vld, input int rc);
        chk({name, "_target"}, int'(bus.target_box), tgt);
        chk({name, "_valid"}, int'(bus.target_valid), vld);
        chk({name, "_round"}, int'(bus.round_count), rc);
    endtask

    initial begin
        resetn               = 1'b0;
        bus.start_game       = 1'b0;
        bus.difficulty_level = 2'd1;
        bus.lfsr_value       = 3'd5;
        bus.box_address      = 3'd0;

        // Reset, then first round with lfsr 5
        to_cyc(1);
        chk("rst1_pulses", int'({bus.timeout_pulse, bus.miss_pulse, bus.hit_pulse}), 0);
        to_cyc(2);
        chk("rst2_pulses", int'({bus.timeout_pulse, bus.miss_pulse, bus.hit_pulse}), 0);
        chk_round("reset", 0, 0, 0);
        resetn         = 1'b1;
        bus.start_game = 1'b1;
        to_cyc(3);
        chk("load_valid", int'(bus.target_valid), 0);
        to_cyc(4);
        chk_round("r1", 5, 1, 1);

        // Hit on target 5, keep holding to prove a single event
        bus.box_address = 3'd5;
        expect_ev(K_HIT, 9);
        to_cyc(9);
        chk_round("r1_hit", 0, 0, 1);
        to_cyc(20);
        bus.box_address = 3'd0;
        bus.lfsr_value  = 3'd3;
        to_cyc(29);
        chk("cool_end_valid", int'(bus.target_valid), 0);

        // Miss on box 6 keeps target 3, then a re-armed strike on 3 hits
        to_cyc(30);
        chk_round("r2", 3, 1, 2);
        bus.box_address = 3'd6;
        expect_ev(K_MIS, 35);
        to_cyc(35);
        chk_round("r2_miss", 3, 1, 2);
        to_cyc(36);
        bus.box_address = 3'd0;
        to_cyc(41);
        bus.box_address = 3'd3;
        expect_ev(K_HIT, 46);
        to_cyc(47);
        bus.box_address      = 3'd0;
        bus.lfsr_value       = 3'd7;
        bus.difficulty_level = 2'd0;

        // Difficulty 0 round times out after 50 cycles
        to_cyc(67);
        chk_round("r3", 7, 1, 3);
        expect_ev(K_TMO, 117);
        to_cyc(116);
        chk("r3_pre_expiry_valid", int'(bus.target_valid), 1);
        to_cyc(117);
        chk("r3_tmo_valid", int'(bus.target_valid), 0);
        to_cyc(120);
        bus.difficulty_level = 2'd1;

        // lfsr repeats previous target 7 -> 1; strike matures on the expiry edge
        to_cyc(138);
        chk_round("r4", 1, 1, 4);
        to_cyc(183);
        bus.box_address = 3'd1;
        expect_ev(K_HIT, 188);
        to_cyc(189);
        bus.box_address = 3'd0;
        bus.lfsr_value  = 3'd0;

        // lfsr 0 after target 1 -> 2; abort while a strike is maturing
        to_cyc(209);
        chk_round("r5", 2, 1, 5);
        to_cyc(210);
        bus.box_address = 3'd2;
        to_cyc(214);
        bus.start_game = 1'b0;
        to_cyc(215);
        chk_round("abort", 0, 0, 5);
        bus.box_address = 3'd0;
        bus.lfsr_value  = 3'd6;

        // New game clears the round count; a 3-cycle glitch yields nothing
        to_cyc(220);
        bus.start_game = 1'b1;
        to_cyc(222);
        chk_round("g2r1", 6, 1, 1);
        expect_ev(K_TMO, 272);
        to_cyc(225);
        bus.box_address = 3'd6;
        to_cyc(228);
        bus.box_address = 3'd0;
        to_cyc(272);
        chk("g2r1_tmo_valid", int'(bus.target_valid), 0);

        // Reset during cooldown, then lfsr 0 with no previous target -> 1
        to_cyc(280);
        resetn = 1'b0;
        to_cyc(281);
        chk_round("midrst", 0, 0, 0);
        chk("midrst_pulses", int'({bus.timeout_pulse, bus.miss_pulse, bus.hit_pulse}), 0);
        to_cyc(282);
        resetn         = 1'b1;
        bus.lfsr_value = 3'd0;
        to_cyc(284);
        chk_round("post_rst", 1, 1, 1);
        to_cyc(286);
        bus.start_game = 1'b0;
        to_cyc(290);
        chk("events_outstanding", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog edge=%0d required finish by edge 290", cyc);
        $fatal(1);
    end

endmodule
